// File: rtl/memref_bridge_pkg.sv
// Shared types and helpers for the memref host bridge: FSM state encoding,
// default geometry and an address range check used by both memories.
package memref_bridge_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SIZE  = 256;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // True when addr indexes a real word of a memory holding size words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int size);
    return addr < $unsigned(size);
  endfunction

endpackage

// File: rtl/memref_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is, so the
// read data returns to 0 on rst while stored contents survive.
// Out-of-range writes are dropped and out-of-range reads return 0.
module memref_sdp_ram
  import memref_bridge_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] rdata_q;

  // Write port: commit only addresses that exist.
  always_ff @(posedge clk) begin
    if (we && addr_in_range(32'(waddr), SIZE)) mem[waddr] <= wdata;
  end

  // Read port: register on enable, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= addr_in_range(32'(raddr), SIZE) ? mem[raddr] : '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memref_host_bridge.sv
// Host-side harness for a memref-port kernel: loads image A, pulses the
// kernel start, serves kernel reads from A, collects kernel writes into C,
// then streams C out with a one-entry holding register for backpressure.
// Optional RUN watchdog is built when MEMREF_BRIDGE_TIMEOUT_EN is defined.
module memref_host_bridge
  import memref_bridge_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int ADDR_W = $clog2(SIZE)
`ifdef MEMREF_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              timeout_err,
  output logic              k_start,
  input  logic              k_done,
  input  logic              k_rd_en,
  input  logic [ADDR_W-1:0] k_rd_addr,
  output logic [WIDTH-1:0]  k_rd_data,
  input  logic              k_wr_en,
  input  logic [ADDR_W-1:0] k_wr_addr,
  input  logic [WIDTH-1:0]  k_wr_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] SIZE_C   = CNT_W'(SIZE);

  state_t           state_q;
  logic [CNT_W-1:0] ld_cnt_q, wr_cnt_q, dr_cnt_q;
  logic             k_start_q;
  logic             ram_vld_q, ram_last_q;
  logic             hold_vld_q, hold_last_q;
  logic [WIDTH-1:0] hold_data_q;
  logic             out_vld_q, out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] a_rdata, c_rdata;
  logic             a_we, a_re, c_we, c_re, pop, out_free, run_done, tmo_hit;
  logic [1:0]       occ;

  // Port enables and drain credit: at most two words in flight or buffered.
  always_comb begin
    a_we     = (state_q == LOAD) && in_valid;
    a_re     = (state_q == RUN) && k_rd_en;
    c_we     = (state_q == RUN) && k_wr_en;
    pop      = out_vld_q && out_ready;
    out_free = !out_vld_q || pop;
    occ      = {1'b0, ram_vld_q} + {1'b0, out_vld_q} + {1'b0, hold_vld_q} - {1'b0, pop};
    c_re     = (state_q == DRAIN) && (dr_cnt_q != SIZE_C) && (occ < 2'd2);
    run_done = (c_we && (wr_cnt_q == LAST_IDX)) || k_done;
  end

  memref_sdp_ram #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) u_ram_a (
    .clk(clk), .rst(rst),
    .we(a_we), .waddr(ld_cnt_q[ADDR_W-1:0]), .wdata(in_data),
    .re(a_re), .raddr(k_rd_addr), .rdata(a_rdata)
  );

  memref_sdp_ram #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) u_ram_c (
    .clk(clk), .rst(rst),
    .we(c_we), .waddr(k_wr_addr), .wdata(k_wr_data),
    .re(c_re), .raddr(dr_cnt_q[ADDR_W-1:0]), .rdata(c_rdata)
  );

`ifdef MEMREF_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;

  assign tmo_hit = (state_q == RUN) && (tmo_cnt_q == TMO_LAST) && !run_done;

  // Watchdog: counts RUN cycles from KICK; the error flag is sticky until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == KICK)     tmo_cnt_q <= '0;
      else if (state_q == RUN) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main sequencer: phase transitions, load/write/drain counters, start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      ld_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      dr_cnt_q  <= '0;
      k_start_q <= 1'b0;
    end else begin
      k_start_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (a_we) begin
            if (ld_cnt_q == LAST_IDX) begin
              ld_cnt_q  <= '0;
              state_q   <= KICK;
              k_start_q <= 1'b1;
            end else begin
              ld_cnt_q <= ld_cnt_q + 1'b1;
            end
          end
        end
        KICK: begin
          wr_cnt_q <= '0;
          state_q  <= RUN;
        end
        RUN: begin
          if (c_we) wr_cnt_q <= wr_cnt_q + 1'b1;
          if (run_done || tmo_hit) state_q <= DRAIN;
        end
        DRAIN: begin
          if (c_re) dr_cnt_q <= dr_cnt_q + 1'b1;
          if (pop && out_last_q) begin
            dr_cnt_q <= '0;
            state_q  <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Drain datapath: RAM output feeds the output register, spilling into the
  // holding register when the output is stalled; hold always drains first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ram_vld_q <= c_re;
      if (c_re) ram_last_q <= (dr_cnt_q == LAST_IDX);
      if (out_free) begin
        if (hold_vld_q) begin
          out_vld_q   <= 1'b1;
          out_data_q  <= hold_data_q;
          out_last_q  <= hold_last_q;
          hold_vld_q  <= ram_vld_q;
          hold_data_q <= c_rdata;
          hold_last_q <= ram_last_q;
        end else if (ram_vld_q) begin
          out_vld_q  <= 1'b1;
          out_data_q <= c_rdata;
          out_last_q <= ram_last_q;
        end else begin
          out_vld_q  <= 1'b0;
          out_last_q <= 1'b0;
        end
      end else if (ram_vld_q) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= c_rdata;
        hold_last_q <= ram_last_q;
      end
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign k_start   = k_start_q;
  assign k_rd_data = a_rdata;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_memref_host_bridge.sv
// Scoreboard bench for memref_host_bridge: the stimulus process pushes the
// expected drain stream when a run completes; a negedge monitor pops and
// compares every output beat and checks stability on stalled cycles.
module tb_memref_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, timeout_err, k_start, k_done;
  logic        k_rd_en, k_wr_en;
  logic [7:0]  k_rd_addr, k_wr_addr;
  logic [31:0] k_rd_data, k_wr_data;

  int n_checks = 0;
  int n_pass   = 0;
  int beats    = 0;

  logic [31:0] a_model [256];
  logic [31:0] c_model [256];
  logic [32:0] exp_q [$];

  logic        stall = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  memref_host_bridge #(
    .WIDTH(32), .SIZE(256), .ADDR_W(8)
`ifdef MEMREF_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err),
    .k_start(k_start), .k_done(k_done),
    .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
    .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", name, act, exp);
  endtask

  // Monitor: compare each accepted beat with the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, stall_data);
        chk("stall_last", 32'(out_last), 32'(stall_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %08h, want no beat", out_data);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("beat_data", out_data, e[31:0]);
          chk("beat_last", 32'(out_last), 32'(e[32]));
          $display("beat %0d data=%08h last=%0d", beats, out_data, out_last);
        end
        beats++;
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end
  end

  task automatic push_expected();
    for (int m = 0; m < 256; m++) exp_q.push_back({(m == 255), c_model[m]});
  endtask

  // Stream A[k]=k, then check the start pulse timing.
  task automatic load_image();
    for (int k = 0; k < 256; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k);
      a_model[k] = 32'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("in_ready_after_load", 32'(in_ready), 32'd0);
    chk("k_start_pulse", 32'(k_start), 32'd1);
    @(posedge clk); #1;
    chk("k_start_single", 32'(k_start), 32'd0);
    chk("busy_in_run", 32'(busy), 32'd1);
    $display("load done, kernel started");
  endtask

  task automatic kwrite(input logic [7:0] addr, input logic [31:0] data, input logic done);
    k_wr_en   = 1'b1;
    k_wr_addr = addr;
    k_wr_data = data;
    k_done    = done;
    @(posedge clk); #1;
    k_wr_en = 1'b0;
    k_done  = 1'b0;
  endtask

  // Transpose kernel: read A[i*16+j], write it to C[j*16+i].
  task automatic transpose_run();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        k_rd_en   = 1'b1;
        k_rd_addr = 8'(i * 16 + j);
        @(posedge clk); #1;
        k_rd_en = 1'b0;
        chk("kernel_read", k_rd_data, a_model[i * 16 + j]);
        c_model[j * 16 + i] = a_model[i * 16 + j];
        kwrite(8'(j * 16 + i), k_rd_data, 1'b0);
      end
    end
    $display("transpose kernel finished");
  endtask

  // Wait for return to LOAD, optionally toggling out_ready each cycle.
  task automatic wait_idle(input int max_cycles, input bit toggle, input int b0, input int want_beats);
    int n;
    n = 0;
    while (!in_ready && n < max_cycles) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    chk("drain_done", 32'(in_ready), 32'd1);
    chk("out_valid_after_last", 32'(out_valid), 32'd0);
    chk("busy_after_drain", 32'(busy), 32'd0);
    chk("beat_count", 32'(beats - b0), 32'(want_beats));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at 1ms");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; k_done = 1'b0;
    k_rd_en = 1'b0; k_rd_addr = '0; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_k_start", 32'(k_start), 32'd0);
    chk("rst_k_rd_data", k_rd_data, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Tests 1-3: load, read latency, transpose, drain.
    load_image();
    k_rd_en = 1'b1; k_rd_addr = 8'h10;
    @(posedge clk); #1;
    k_rd_en = 1'b0;
    chk("rd_latency", k_rd_data, 32'h10);
    @(posedge clk); #1;
    chk("rd_hold", k_rd_data, 32'h10);
    transpose_run();
    push_expected();
    b0 = beats;
    wait_idle(2000, 1'b0, b0, 256);

    // Test 4: same run with alternating out_ready.
    load_image();
    transpose_run();
    push_expected();
    b0 = beats;
    wait_idle(2000, 1'b1, b0, 256);

    // Test 5: early done with a final write to C[5].
    load_image();
    for (int n = 0; n < 10; n++) begin
      c_model[n] = 32'hA000 + 32'(n);
      kwrite(8'(n), 32'hA000 + 32'(n), 1'b0);
    end
    c_model[5] = 32'hBEEF;
    kwrite(8'd5, 32'hBEEF, 1'b1);
    push_expected();
    b0 = beats;
    @(posedge clk); #1;
    chk("early_done_no_valid_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("early_done_first_valid", 32'(out_valid), 32'd1);
    wait_idle(2000, 1'b0, b0, 256);

    // Test 6: reset in the middle of a drain, then a full rerun.
    load_image();
    k_done = 1'b1;
    @(posedge clk); #1;
    k_done = 1'b0;
    push_expected();
    b0 = beats;
    for (int n = 0; n < 1000 && (beats - b0) < 100; n++) begin
      @(posedge clk); #1;
    end
    chk("beats_before_rst", 32'(beats - b0), 32'd100);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    load_image();
    transpose_run();
    push_expected();
    b0 = beats;
    wait_idle(2000, 1'b0, b0, 256);

    // Test 7: kernel never writes.
    load_image();
`ifdef MEMREF_BRIDGE_TIMEOUT_EN
    repeat (63) @(posedge clk);
    #1;
    chk("tmo_not_yet", 32'(timeout_err), 32'd0);
    push_expected();
    b0 = beats;
    @(posedge clk); #1;
    chk("tmo_set", 32'(timeout_err), 32'd1);
    wait_idle(2000, 1'b0, b0, 256);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (200) @(posedge clk);
    #1;
    chk("no_tmo_busy", 32'(busy), 32'd1);
    chk("no_tmo_out_valid", 32'(out_valid), 32'd0);
    chk("no_tmo_err", 32'(timeout_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
